// File: rtl/imem_fetch_bridge_if.sv
// ---------------------------------------------------------------------------
// imem_fetch_bridge_if
// Bundles the icache refill handshake and the instruction_mem port seen by
// imem_fetch_bridge. The "slave" modport is the bridge side. The "master"
// modport is the icache plus the memory model that surrounds the bridge.
// ---------------------------------------------------------------------------
interface imem_fetch_bridge_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic [XLEN-1:0]   req_addr;
    logic              req_ready;
    logic              abort;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_data;
    logic              resp_err;
    logic [ADDR_W-1:0] imem_addr;
    logic [XLEN-1:0]   imem_rdata;
    logic              busy;

    modport slave (
        input  req_valid, req_addr, abort, imem_rdata,
        output req_ready, resp_valid, resp_data, resp_err, imem_addr, busy
    );

    modport master (
        output req_valid, req_addr, abort, imem_rdata,
        input  req_ready, resp_valid, resp_data, resp_err, imem_addr, busy
    );
endinterface

// File: rtl/imem_fetch_bridge.sv
// ---------------------------------------------------------------------------
// imem_fetch_bridge
// Multi-cycle bridge between the icache refill port and instruction_mem.
// An accepted aligned request drives the word address to the memory and
// waits LATENCY edges before it captures the read data. The captured word is
// presented for exactly one cycle with resp_valid. A misaligned request gets
// an immediate error response that carries a NOP word, and the memory is not
// accessed. The abort input cancels an outstanding refill, so a control
// hazard never receives a stale instruction.
//
// Optional feature: define IMEM_BRIDGE_PREFETCH_EN to add a one-entry
// next-line prefetch buffer. When the macro is not defined, the bridge has
// no buffer and no PF_* states.
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module imem_fetch_bridge #(
    parameter int              XLEN     = `XLEN,
    parameter int              ADDR_W   = 10,
    parameter int              LATENCY  = 3,
    parameter logic [XLEN-1:0] NOP_WORD = XLEN'(32'h0000_0013)
) (
    input  logic                    clk,
    input  logic                    reset,   // asynchronous, active low
    imem_fetch_bridge_if.slave      bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_RESP    = 3'd2
`ifdef IMEM_BRIDGE_PREFETCH_EN
        ,
        ST_PF_WAIT = 3'd3,
        ST_PF_RESP = 3'd4
`endif
    } state_t;

    // Counter preload. The capture happens at the edge where the counter is
    // zero, which is LATENCY edges after the accept edge.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    // Word address seen by instruction_mem. Upper byte-address bits are
    // dropped, so fetches wrap inside the array.
    function automatic logic [ADDR_W-1:0] word_addr_f(input logic [XLEN-1:0] byte_addr);
        word_addr_f = byte_addr[ADDR_W+1:2];
    endfunction

    function automatic logic is_aligned_f(input logic [XLEN-1:0] byte_addr);
        is_aligned_f = (byte_addr[1:0] == 2'b00);
    endfunction

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic              resp_valid_q;
    logic [XLEN-1:0]   resp_data_q;
    logic              resp_err_q;

`ifdef IMEM_BRIDGE_PREFETCH_EN
    logic              pf_valid_q;
    logic [XLEN-1:0]   pf_addr_q;
    logic [XLEN-1:0]   pf_data_q;
    logic [XLEN-1:0]   last_addr_q;   // address of the demand word just served
    logic              merged_q;      // a demand request is riding on the prefetch
    logic [XLEN-1:0]   next_line_s;
`endif

    logic req_ready_s;
    logic accept_s;
    logic pf_hit_s;

    // Decode acceptance from the current state. Nothing is ready while the
    // bridge is held in reset.
    always_comb begin
        req_ready_s = 1'b0;
        pf_hit_s    = 1'b0;
        if (!reset) begin
            req_ready_s = 1'b0;
        end else if (state_q == ST_IDLE) begin
            req_ready_s = 1'b1;
        end
`ifdef IMEM_BRIDGE_PREFETCH_EN
        else if (state_q == ST_PF_WAIT) begin
            req_ready_s = !merged_q;
        end
`endif
        else begin
            req_ready_s = 1'b0;
        end
`ifdef IMEM_BRIDGE_PREFETCH_EN
        if (pf_valid_q && (bus.req_addr == pf_addr_q)) begin
            pf_hit_s = 1'b1;
        end else begin
            pf_hit_s = 1'b0;
        end
`else
        pf_hit_s = 1'b0;
`endif
    end

    // Abort takes priority over a new request.
    assign accept_s = bus.req_valid & req_ready_s & ~bus.abort;

`ifdef IMEM_BRIDGE_PREFETCH_EN
    assign next_line_s = last_addr_q + XLEN'(32'd4);
`endif

    // Bridge FSM with the counter, address, response and prefetch registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            imem_addr_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
`ifdef IMEM_BRIDGE_PREFETCH_EN
            pf_valid_q   <= 1'b0;
            pf_addr_q    <= '0;
            pf_data_q    <= '0;
            last_addr_q  <= '0;
            merged_q     <= 1'b0;
`endif
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (!is_aligned_f(bus.req_addr)) begin
                            resp_data_q  <= NOP_WORD;
                            resp_err_q   <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= ST_RESP;
                        end else if (pf_hit_s) begin
`ifdef IMEM_BRIDGE_PREFETCH_EN
                            resp_data_q  <= pf_data_q;
                            resp_err_q   <= 1'b0;
                            resp_valid_q <= 1'b1;
                            pf_valid_q   <= 1'b0;
                            last_addr_q  <= bus.req_addr;
                            state_q      <= ST_PF_RESP;
`else
                            state_q      <= ST_IDLE;
`endif
                        end else begin
                            imem_addr_q  <= word_addr_f(bus.req_addr);
                            cnt_q        <= CNT_LOAD;
`ifdef IMEM_BRIDGE_PREFETCH_EN
                            last_addr_q  <= bus.req_addr;
`endif
                            state_q      <= ST_WAIT;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_WAIT: begin
                    if (bus.abort) begin
                        // Cancelled refill: no capture and no response.
                        state_q <= ST_IDLE;
                    end else if (cnt_q == 4'd0) begin
                        resp_data_q  <= bus.imem_rdata;
                        resp_err_q   <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                ST_RESP: begin
`ifdef IMEM_BRIDGE_PREFETCH_EN
                    // After a good demand fetch with the icache idle, start
                    // fetching the next sequential word.
                    if (!resp_err_q && !bus.req_valid && !bus.abort) begin
                        pf_addr_q   <= next_line_s;
                        pf_valid_q  <= 1'b0;
                        imem_addr_q <= word_addr_f(next_line_s);
                        cnt_q       <= CNT_LOAD;
                        merged_q    <= 1'b0;
                        state_q     <= ST_PF_WAIT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
`else
                    state_q <= ST_IDLE;
`endif
                end

`ifdef IMEM_BRIDGE_PREFETCH_EN
                ST_PF_WAIT: begin
                    if (bus.abort) begin
                        merged_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else if (accept_s && (bus.req_addr != pf_addr_q)) begin
                        // Demand for another line: drop the prefetch.
                        merged_q <= 1'b0;
                        if (!is_aligned_f(bus.req_addr)) begin
                            resp_data_q  <= NOP_WORD;
                            resp_err_q   <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= ST_RESP;
                        end else begin
                            imem_addr_q <= word_addr_f(bus.req_addr);
                            cnt_q       <= CNT_LOAD;
                            last_addr_q <= bus.req_addr;
                            state_q     <= ST_WAIT;
                        end
                    end else if (cnt_q == 4'd0) begin
                        pf_data_q <= bus.imem_rdata;
                        merged_q  <= 1'b0;
                        if (merged_q || accept_s) begin
                            resp_data_q  <= bus.imem_rdata;
                            resp_err_q   <= 1'b0;
                            resp_valid_q <= 1'b1;
                            pf_valid_q   <= 1'b0;
                            last_addr_q  <= pf_addr_q;
                            state_q      <= ST_PF_RESP;
                        end else begin
                            pf_valid_q <= 1'b1;
                            state_q    <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (accept_s) begin
                            merged_q <= 1'b1;
                        end else begin
                            merged_q <= merged_q;
                        end
                    end
                end

                ST_PF_RESP: begin
                    if (!bus.req_valid && !bus.abort) begin
                        pf_addr_q   <= next_line_s;
                        pf_valid_q  <= 1'b0;
                        imem_addr_q <= word_addr_f(next_line_s);
                        cnt_q       <= CNT_LOAD;
                        merged_q    <= 1'b0;
                        state_q     <= ST_PF_WAIT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
`endif

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
`ifdef IMEM_BRIDGE_PREFETCH_EN
            // A control hazard makes any buffered next-line word useless.
            if (bus.abort) begin
                pf_valid_q <= 1'b0;
            end
`endif
        end
    end

    assign bus.req_ready  = req_ready_s;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_imem_fetch_bridge.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_bridge
// Directed bench for imem_fetch_bridge in its default build (no prefetch),
// with LATENCY=3. instruction_mem is modelled as a registered array: read
// data follows the address by one clock.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_imem_fetch_bridge;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_mis;

    logic [31:0] mem [0:1023];

    imem_fetch_bridge_if #(.XLEN(32), .ADDR_W(10)) bus ();

    imem_fetch_bridge #(
        .XLEN    (32),
        .ADDR_W  (10),
        .LATENCY (3),
        .NOP_WORD(32'h0000_0013)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instruction_mem model: registered read
    always @(posedge clk) begin
        bus.imem_rdata <= mem[bus.imem_addr];
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle request. Returns just after the accept edge.
    task automatic request(input logic [31:0] addr);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        tick();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_mis = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
        mem[4] = 32'hDEAD_BEEF;
        mem[9] = 32'hCAFE_F00D;

        reset          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'h0;
        bus.abort      = 1'b0;
        #1;
        check_vec("rst_resp_valid", bus.resp_valid, 32'd0);
        check_vec("rst_resp_err",   bus.resp_err,   32'd0);
        check_vec("rst_resp_data",  bus.resp_data,  32'd0);
        check_vec("rst_imem_addr",  bus.imem_addr,  32'd0);
        check_vec("rst_req_ready",  bus.req_ready,  32'd0);
        check_vec("rst_busy",       bus.busy,       32'd0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check_vec("rel_req_ready", bus.req_ready, 32'd1);

        // Aligned fetch at 0x10: capture at edge 3, response in the next cycle
        request(32'h0000_0010);
        check_vec("t2_imem_addr", bus.imem_addr, 32'd4);
        check_vec("t2_busy",      bus.busy,      32'd1);
        check_vec("t2_ready_lo",  bus.req_ready, 32'd0);
        check_vec("t2_rv_e0",     bus.resp_valid, 32'd0);
        tick();
        check_vec("t2_rv_e1", bus.resp_valid, 32'd0);
        tick();
        check_vec("t2_rv_e2", bus.resp_valid, 32'd0);
        tick();
        check_vec("t2_rv_e3",    bus.resp_valid, 32'd1);
        check_vec("t2_data",     bus.resp_data,  32'hDEAD_BEEF);
        check_vec("t2_err",      bus.resp_err,   32'd0);
        check_vec("t2_ready_rs", bus.req_ready,  32'd0);
        tick();
        check_vec("t2_rv_e4",    bus.resp_valid, 32'd0);
        check_vec("t2_ready_e4", bus.req_ready,  32'd1);
        check_vec("t2_busy_e4",  bus.busy,       32'd0);
        check_vec("t2_data_hold", bus.resp_data, 32'hDEAD_BEEF);

        // Misaligned request: immediate error response, no memory access
        request(32'h0000_0006);
        check_vec("t3_rv",    bus.resp_valid, 32'd1);
        check_vec("t3_err",   bus.resp_err,   32'd1);
        check_vec("t3_data",  bus.resp_data,  32'h0000_0013);
        check_vec("t3_iaddr", bus.imem_addr,  32'd4);
        tick();
        check_vec("t3_rv_off", bus.resp_valid, 32'd0);
        check_vec("t3_ready",  bus.req_ready,  32'd1);

        // Abort in WAIT: sampled at edge 2, so there is no response
        request(32'h0000_0020);
        check_vec("t4_iaddr", bus.imem_addr, 32'd8);
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_vec("t4_rv_e2", bus.resp_valid, 32'd0);
        tick();
        check_vec("t4_busy_e3", bus.busy,       32'd0);
        check_vec("t4_rv_e3",   bus.resp_valid, 32'd0);
        tick();
        check_vec("t4_rv_e4",   bus.resp_valid, 32'd0);
        check_vec("t4_data",    bus.resp_data,  32'h0000_0013);
        request(32'h0000_0024);
        check_vec("t4b_iaddr", bus.imem_addr, 32'd9);
        tick();
        tick();
        check_vec("t4b_rv_e2", bus.resp_valid, 32'd0);
        tick();
        check_vec("t4b_rv_e3", bus.resp_valid, 32'd1);
        check_vec("t4b_data",  bus.resp_data,  32'hCAFE_F00D);
        check_vec("t4b_err",   bus.resp_err,   32'd0);
        tick();

        // Abort at the same edge where the counter reaches zero: no capture
        request(32'h0000_0010);
        tick();
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_vec("tac_rv",   bus.resp_valid, 32'd0);
        check_vec("tac_busy", bus.busy,       32'd0);
        check_vec("tac_data", bus.resp_data,  32'hCAFE_F00D);
        tick();
        check_vec("tac_rv2",  bus.resp_valid, 32'd0);

        // Abort together with req_valid in IDLE: not accepted
        bus.abort     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0030;
        tick();
        bus.abort     = 1'b0;
        bus.req_valid = 1'b0;
        check_vec("t5_busy",  bus.busy,      32'd0);
        check_vec("t5_ready", bus.req_ready, 32'd1);
        check_vec("t5_iaddr", bus.imem_addr, 32'd4);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_vec("t5_no_rv", bus.resp_valid, 32'd0);
        end

        // Abort during RESP is ignored: the response is still presented
        request(32'h0000_0020);
        tick();
        tick();
        tick();
        bus.abort = 1'b1;
        #1;
        check_vec("trs_rv",   bus.resp_valid, 32'd1);
        check_vec("trs_data", bus.resp_data,  32'h1000_0008);
        tick();
        bus.abort = 1'b0;
        check_vec("trs_rv_off", bus.resp_valid, 32'd0);
        check_vec("trs_ready",  bus.req_ready,  32'd1);

        // Reset asserted mid-WAIT clears the outputs immediately
        request(32'h0000_0010);
        tick();
        #2;
        reset = 1'b0;
        #1;
        check_vec("t1_rv",    bus.resp_valid, 32'd0);
        check_vec("t1_busy",  bus.busy,       32'd0);
        check_vec("t1_iaddr", bus.imem_addr,  32'd0);
        check_vec("t1_ready", bus.req_ready,  32'd0);
        check_vec("t1_data",  bus.resp_data,  32'd0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_vec("t1_no_stray", bus.resp_valid, 32'd0);
        end
        check_vec("t1_ready_rel", bus.req_ready, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
